// File: rtl/cr_prefix_fe_cmpn_pkg.sv
// Shared types for the prefix feature-extract front end: the compare-mode enums
// and the channel-count limit for cr_prefix_fe_cmpn.
package cr_prefixPKG;

  typedef enum logic [1:0] {
    PREFIX_CMP_EQ = 2'd0,
    PREFIX_CMP_NE = 2'd1,
    PREFIX_CMP_LT = 2'd2,
    PREFIX_CMP_GE = 2'd3
  } prefix_cmp_type_e;

  // Mode values 6 and 7 are reserved and never produce a match.
  typedef enum logic [2:0] {
    CMPN_EQ    = 3'd0,
    CMPN_GTEQ  = 3'd1,
    CMPN_LT    = 3'd2,
    CMPN_EQOP  = 3'd3,
    CMPN_RANGE = 3'd4,
    CMPN_NE    = 3'd5,
    CMPN_RSVD6 = 3'd6,
    CMPN_RSVD7 = 3'd7
  } prefix_cmpn_type_e;

  localparam int unsigned CR_PREFIX_CMPN_MAX = 16;

endpackage

// File: rtl/cr_prefix_fe_cmpn_lane.sv
// One compare channel: mode comparator, consecutive-match run counter and,
// when CR_PREFIX_FE_HIT_CNT_EN is defined, a saturating hit counter.
module cr_prefix_fe_cmpn_lane
  import cr_prefixPKG::*;
#(
  parameter int unsigned CHAR_W = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [CHAR_W-1:0] char_i,
  input  logic              valid_i,
  input  logic              sof_i,
  input  logic              clr_i,
  input  logic [CHAR_W-1:0] lo_i,
  input  logic [CHAR_W-1:0] hi_i,
  input  logic [2:0]        type_i,
  input  logic [CNT_W-1:0]  thresh_i,
  output logic              cmp_o,
  output logic              run_hit_o,
  output logic [CNT_W-1:0]  hit_cnt_o
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  prefix_cmpn_type_e mode;
  logic              raw;
  logic              cmp;
  logic [CNT_W-1:0]  base;
  logic [CNT_W-1:0]  run_cnt_q, run_cnt_d;
  logic              cmp_q;
  logic              run_hit_q, run_hit_d;

  assign mode = prefix_cmpn_type_e'(type_i);

  always_comb begin
    raw = 1'b0;
    case (mode)
      CMPN_EQ, CMPN_EQOP: raw = (char_i == lo_i);
      CMPN_GTEQ:          raw = (char_i >= lo_i);
      CMPN_LT:            raw = (char_i < lo_i);
      CMPN_RANGE:         raw = (char_i >= lo_i) && (char_i <= hi_i);
      CMPN_NE:            raw = (char_i != lo_i);
      default:            raw = 1'b0;
    endcase
  end

  assign cmp = raw & valid_i;

  // sof restarts the run from zero so the current character counts as run 1.
  always_comb begin
    base      = (sof_i && valid_i) ? '0 : run_cnt_q;
    run_cnt_d = run_cnt_q;
    if (valid_i) begin
      if (!cmp)                run_cnt_d = '0;
      else if (base == CntMax) run_cnt_d = base;
      else                     run_cnt_d = base + 1'b1;
    end
    run_hit_d = valid_i && (thresh_i != '0) && (run_cnt_d >= thresh_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_cnt_q <= '0;
      cmp_q     <= 1'b0;
      run_hit_q <= 1'b0;
    end else begin
      run_cnt_q <= run_cnt_d;
      cmp_q     <= cmp;
      run_hit_q <= run_hit_d;
    end
  end

  assign cmp_o     = cmp_q;
  assign run_hit_o = run_hit_q;

`ifdef CR_PREFIX_FE_HIT_CNT_EN
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;

  always_comb begin
    hit_cnt_d = hit_cnt_q;
    if (clr_i)                            hit_cnt_d = '0;
    else if (cmp && hit_cnt_q != CntMax)  hit_cnt_d = hit_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) hit_cnt_q <= '0;
    else         hit_cnt_q <= hit_cnt_d;
  end

  assign hit_cnt_o = hit_cnt_q;
`else
  logic unused_clr;
  assign unused_clr = clr_i;
  assign hit_cnt_o  = '0;
`endif

endmodule

// File: rtl/cr_prefix_fe_cmpn.sv
// Multi-channel character comparator for the prefix feature-extract path.
// Hit counters exist only when CR_PREFIX_FE_HIT_CNT_EN is defined.
module cr_prefix_fe_cmpn
  import cr_prefixPKG::*;
#(
  parameter int unsigned NUM_CMP = 4,
  parameter int unsigned CHAR_W  = 8,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [CHAR_W-1:0]          char_in,
  input  logic                       char_valid,
  input  logic                       sof,
  input  logic                       clr,
  input  logic [NUM_CMP*CHAR_W-1:0]  match_lo,
  input  logic [NUM_CMP*CHAR_W-1:0]  match_hi,
  input  logic [NUM_CMP*3-1:0]       cmp_type,
  input  logic [NUM_CMP*CNT_W-1:0]   run_thresh,
  output logic [NUM_CMP-1:0]         cmp_r,
  output logic [NUM_CMP-1:0]         run_hit_r,
  output logic                       char_valid_r,
  output logic [NUM_CMP*CNT_W-1:0]   hit_cnt
);

  if (NUM_CMP < 1 || NUM_CMP > CR_PREFIX_CMPN_MAX) begin : g_num_cmp_chk
    $error("cr_prefix_fe_cmpn: NUM_CMP out of range");
  end

  logic char_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) char_valid_q <= 1'b0;
    else        char_valid_q <= char_valid;
  end

  assign char_valid_r = char_valid_q;

  for (genvar i = 0; i < NUM_CMP; i++) begin : g_lane
    cr_prefix_fe_cmpn_lane #(
      .CHAR_W (CHAR_W),
      .CNT_W  (CNT_W)
    ) u_lane (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .char_i    (char_in),
      .valid_i   (char_valid),
      .sof_i     (sof),
      .clr_i     (clr),
      .lo_i      (match_lo[i*CHAR_W +: CHAR_W]),
      .hi_i      (match_hi[i*CHAR_W +: CHAR_W]),
      .type_i    (cmp_type[i*3 +: 3]),
      .thresh_i  (run_thresh[i*CNT_W +: CNT_W]),
      .cmp_o     (cmp_r[i]),
      .run_hit_o (run_hit_r[i]),
      .hit_cnt_o (hit_cnt[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_cr_prefix_fe_cmpn.sv
// Self-checking bench for cr_prefix_fe_cmpn against a behavioural channel model.
module tb_cr_prefix_fe_cmpn;

  localparam int unsigned NC   = 6;
  localparam int unsigned CW   = 8;
  localparam int unsigned NW   = 4;
  localparam int          SATV = 15;
`ifdef CR_PREFIX_FE_HIT_CNT_EN
  localparam bit HIT_EN = 1'b1;
`else
  localparam bit HIT_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [CW-1:0]     char_in = '0;
  logic              char_valid = 1'b0;
  logic              sof = 1'b0;
  logic              clr = 1'b0;
  logic [NC*CW-1:0]  match_lo = '0;
  logic [NC*CW-1:0]  match_hi = '0;
  logic [NC*3-1:0]   cmp_type = '0;
  logic [NC*NW-1:0]  run_thresh = '0;
  logic [NC-1:0]     cmp_r, run_hit_r;
  logic              char_valid_r;
  logic [NC*NW-1:0]  hit_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  int               m_run[NC];
  int               m_hit[NC];
  logic [NC-1:0]    exp_cmp, exp_rh;
  logic             exp_cv;
  logic [NC*NW-1:0] exp_hc;

  cr_prefix_fe_cmpn #(
    .NUM_CMP (NC),
    .CHAR_W  (CW),
    .CNT_W   (NW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .char_in      (char_in),
    .char_valid   (char_valid),
    .sof          (sof),
    .clr          (clr),
    .match_lo     (match_lo),
    .match_hi     (match_hi),
    .cmp_type     (cmp_type),
    .run_thresh   (run_thresh),
    .cmp_r        (cmp_r),
    .run_hit_r    (run_hit_r),
    .char_valid_r (char_valid_r),
    .hit_cnt      (hit_cnt)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      m_run[i] = 0;
      m_hit[i] = 0;
    end
    exp_cmp = '0;
    exp_rh  = '0;
    exp_cv  = 1'b0;
    exp_hc  = '0;
  endtask

  // Predicts the outputs after the next rising edge from the present inputs.
  task automatic model_step();
    exp_cv = char_valid;
    for (int i = 0; i < NC; i++) begin
      int c, lo, hi, md, th, nxt;
      bit hit;
      c  = int'(char_in);
      lo = int'(match_lo[i*CW +: CW]);
      hi = int'(match_hi[i*CW +: CW]);
      md = int'(cmp_type[i*3 +: 3]);
      th = int'(run_thresh[i*NW +: NW]);
      case (md)
        0, 3:    hit = (c == lo);
        1:       hit = (c >= lo);
        2:       hit = (c < lo);
        4:       hit = (c >= lo) && (c <= hi);
        5:       hit = (c != lo);
        default: hit = 1'b0;
      endcase
      hit = hit && char_valid;
      if (!char_valid) nxt = m_run[i];
      else if (!hit)   nxt = 0;
      else begin
        nxt = (sof ? 0 : m_run[i]) + 1;
        if (nxt > SATV) nxt = SATV;
      end
      m_run[i]   = nxt;
      exp_cmp[i] = hit;
      exp_rh[i]  = char_valid && (th != 0) && (nxt >= th);
      if (HIT_EN) begin
        if (clr) m_hit[i] = 0;
        else if (hit && m_hit[i] < SATV) m_hit[i] = m_hit[i] + 1;
      end
      exp_hc[i*NW +: NW] = NW'(m_hit[i]);
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int i, input int md, input int lo, input int hi, input int th);
    cmp_type[i*3 +: 3]    = 3'(md);
    match_lo[i*CW +: CW]  = CW'(lo);
    match_hi[i*CW +: CW]  = CW'(hi);
    run_thresh[i*NW +: NW] = NW'(th);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    char_valid = 1'b0;
    sof = 1'b0;
    clr = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_tests++; if (cmp_r !== '0) begin n_fail++; $display("FAIL reset_cmp_r: got %h expected 0", cmp_r); end
    n_tests++; if (run_hit_r !== '0) begin n_fail++; $display("FAIL reset_run_hit_r: got %h expected 0", run_hit_r); end
    n_tests++; if (char_valid_r !== 1'b0) begin n_fail++; $display("FAIL reset_char_valid_r: got %b expected 0", char_valid_r); end
    n_tests++; if (hit_cnt !== '0) begin n_fail++; $display("FAIL reset_hit_cnt: got %h expected 0", hit_cnt); end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_mode_sweep();
    logic [CW-1:0] chars[5];
    logic [NC-1:0] tbl[5];
    chars = '{8'h3F, 8'h40, 8'h41, 8'h5A, 8'h5B};
    tbl   = '{6'b100100, 6'b011011, 6'b110010, 6'b110010, 6'b100010};
    do_reset();
    for (int i = 0; i < NC; i++) set_ch(i, i, 'h40, 'h5A, 0);
    for (int k = 0; k < 5; k++) begin
      char_in = chars[k];
      char_valid = 1'b1;
      cycle();
      n_tests++; if (cmp_r !== tbl[k]) begin n_fail++; $display("FAIL mode_sweep_table c=%h: got %b expected %b", chars[k], cmp_r, tbl[k]); end
      n_tests++; if (cmp_r !== exp_cmp) begin n_fail++; $display("FAIL mode_sweep_model c=%h: got %b expected %b", chars[k], cmp_r, exp_cmp); end
      n_tests++; if (hit_cnt !== exp_hc) begin n_fail++; $display("FAIL mode_sweep_hit_cnt: got %h expected %h", hit_cnt, exp_hc); end
    end
  endtask

  task automatic test_invalid_gating();
    set_ch(2, 2, 'h10, 0, 0);
    char_in = 8'h00;
    char_valid = 1'b0;
    cycle();
    n_tests++; if (cmp_r[2] !== 1'b0) begin n_fail++; $display("FAIL invalid_lt_cmp: got %b expected 0", cmp_r[2]); end
    n_tests++; if (cmp_r !== '0) begin n_fail++; $display("FAIL invalid_all_cmp: got %b expected 0", cmp_r); end
    n_tests++; if (char_valid_r !== 1'b0) begin n_fail++; $display("FAIL invalid_char_valid_r: got %b expected 0", char_valid_r); end
  endtask

  task automatic test_run_thresh();
    logic [CW-1:0] chars[6];
    logic          vals[6];
    logic          e_rh[6];
    logic          e_cmp[6];
    chars = '{8'h41, 8'h41, 8'h41, 8'h41, 8'h42, 8'h41};
    vals  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    e_rh  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    e_cmp = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < NC; i++) set_ch(i, 0, 'h41, 'h41, 3);
    for (int k = 0; k < 6; k++) begin
      char_in = chars[k];
      char_valid = vals[k];
      cycle();
      n_tests++; if (run_hit_r[0] !== e_rh[k]) begin n_fail++; $display("FAIL run_thresh_hit step %0d: got %b expected %b", k, run_hit_r[0], e_rh[k]); end
      n_tests++; if (cmp_r[0] !== e_cmp[k]) begin n_fail++; $display("FAIL run_thresh_cmp step %0d: got %b expected %b", k, cmp_r[0], e_cmp[k]); end
      n_tests++; if (run_hit_r !== exp_rh) begin n_fail++; $display("FAIL run_thresh_model step %0d: got %b expected %b", k, run_hit_r, exp_rh); end
    end
  endtask

  task automatic test_sof_restart();
    logic sofs[3];
    logic e_rh[3];
    sofs = '{1'b0, 1'b1, 1'b0};
    e_rh = '{1'b0, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < NC; i++) set_ch(i, 0, 'h41, 'h41, 2);
    for (int k = 0; k < 3; k++) begin
      char_in = 8'h41;
      char_valid = 1'b1;
      sof = sofs[k];
      cycle();
      n_tests++; if (run_hit_r[0] !== e_rh[k]) begin n_fail++; $display("FAIL sof_restart step %0d: got %b expected %b", k, run_hit_r[0], e_rh[k]); end
    end
    sof = 1'b0;
  endtask

  task automatic test_saturation_clr();
    logic [NW-1:0] sat_exp, one_exp;
    sat_exp = HIT_EN ? NW'(15) : '0;
    one_exp = HIT_EN ? NW'(1) : '0;
    do_reset();
    for (int i = 0; i < NC; i++) set_ch(i, 0, 'h41, 'h41, 15);
    char_in = 8'h41;
    char_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cycle();
      n_tests++; if (run_hit_r !== exp_rh) begin n_fail++; $display("FAIL sat_run_hit step %0d: got %b expected %b", k, run_hit_r, exp_rh); end
    end
    n_tests++; if (hit_cnt[NW-1:0] !== sat_exp) begin n_fail++; $display("FAIL sat_hit_cnt: got %0d expected %0d", hit_cnt[NW-1:0], sat_exp); end
    n_tests++; if (run_hit_r[0] !== 1'b1) begin n_fail++; $display("FAIL sat_run_hold: got %b expected 1", run_hit_r[0]); end
    clr = 1'b1;
    cycle();
    n_tests++; if (hit_cnt !== '0) begin n_fail++; $display("FAIL clr_coincident: got %h expected 0", hit_cnt); end
    n_tests++; if (run_hit_r[0] !== 1'b1) begin n_fail++; $display("FAIL clr_run_hold: got %b expected 1", run_hit_r[0]); end
    clr = 1'b0;
    cycle();
    n_tests++; if (hit_cnt[NW-1:0] !== one_exp) begin n_fail++; $display("FAIL after_clr_count: got %0d expected %0d", hit_cnt[NW-1:0], one_exp); end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < NC; i++) set_ch(i, 0, 'h41, 'h41, 2);
    char_in = 8'h41;
    char_valid = 1'b1;
    cycle();
    cycle();
    n_tests++; if (run_hit_r[0] !== 1'b1) begin n_fail++; $display("FAIL async_pre_hit: got %b expected 1", run_hit_r[0]); end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++; if (cmp_r !== '0) begin n_fail++; $display("FAIL async_cmp_r: got %b expected 0", cmp_r); end
    n_tests++; if (run_hit_r !== '0) begin n_fail++; $display("FAIL async_run_hit_r: got %b expected 0", run_hit_r); end
    n_tests++; if (char_valid_r !== 1'b0) begin n_fail++; $display("FAIL async_char_valid_r: got %b expected 0", char_valid_r); end
    n_tests++; if (hit_cnt !== '0) begin n_fail++; $display("FAIL async_hit_cnt: got %h expected 0", hit_cnt); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    n_tests++; if (run_hit_r[0] !== 1'b0) begin n_fail++; $display("FAIL async_first_run: got %b expected 0", run_hit_r[0]); end
    n_tests++; if (cmp_r[0] !== 1'b1) begin n_fail++; $display("FAIL async_first_cmp: got %b expected 1", cmp_r[0]); end
    cycle();
    n_tests++; if (run_hit_r[0] !== 1'b1) begin n_fail++; $display("FAIL async_second_run: got %b expected 1", run_hit_r[0]); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < NC; i++)
      set_ch(i, $urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 4));
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 31) == 0)
        set_ch($urandom_range(0, NC-1), $urandom_range(0, 7), $urandom_range(0, 255),
               $urandom_range(0, 255), $urandom_range(0, 5));
      if ($urandom_range(0, 1) == 0) char_in = CW'($urandom_range(0, 255));
      else begin
        int ch;
        ch = $urandom_range(0, NC-1);
        char_in = match_lo[ch*CW +: CW] + CW'($urandom_range(0, 1));
      end
      char_valid = ($urandom_range(0, 9) < 8);
      sof = ($urandom_range(0, 9) == 0);
      clr = ($urandom_range(0, 19) == 0);
      cycle();
      n_tests++; if (cmp_r !== exp_cmp) begin n_fail++; $display("FAIL rand_cmp_r @%0d: got %b expected %b", k, cmp_r, exp_cmp); end
      n_tests++; if (run_hit_r !== exp_rh) begin n_fail++; $display("FAIL rand_run_hit_r @%0d: got %b expected %b", k, run_hit_r, exp_rh); end
      n_tests++; if (char_valid_r !== exp_cv) begin n_fail++; $display("FAIL rand_char_valid_r @%0d: got %b expected %b", k, char_valid_r, exp_cv); end
      n_tests++; if (hit_cnt !== exp_hc) begin n_fail++; $display("FAIL rand_hit_cnt @%0d: got %h expected %h", k, hit_cnt, exp_hc); end
    end
    sof = 1'b0;
    clr = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_mode_sweep();
    test_invalid_gating();
    test_run_thresh();
    test_sof_restart();
    test_saturation_clr();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
